// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter and sequencer sharing the single
//               read/write port of the data memory between the pipeline MEM
//               stage (port 0) and the debug/loader port (port 1). Each
//               transaction is a 64-bit big-endian doubleword at a byte
//               address; out-of-range addresses complete with an error flag.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_BYTES  = 256,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [63:0] p0_addr,
  input  logic [63:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [63:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [63:0] p1_addr,
  input  logic [63:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [63:0] p1_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_add,
  output logic [63:0] mem_in,
  input  logic [63:0] mem_out,
  output logic        busy,
  output logic        grant_id
);

  // Highest legal doubleword start address.
  localparam logic [63:0] c_max_addr = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  // Transaction context latched at grant time.
  logic        r_we;
  logic        r_oob;
  logic        r_last;
  logic        r_grant_id;

  // Registered outputs.
  logic        r_busy;
  logic        r_p0_ack, r_p1_ack;
  logic        r_p0_err, r_p1_err;
  logic [63:0] r_p0_rdata, r_p1_rdata;
  logic        r_mem_rd, r_mem_wr;
  logic [63:0] r_mem_add, r_mem_in;

  // Next-state values from the FSM.
  logic        w_grant;
  logic        w_busy_nx;
  logic        w_p0_ack_nx, w_p1_ack_nx;
  logic        w_p0_err_nx, w_p1_err_nx;
  logic [63:0] w_p0_rdata_nx, w_p1_rdata_nx;
  logic        w_mem_rd_nx, w_mem_wr_nx;
  logic [63:0] w_mem_add_nx, w_mem_in_nx;
  logic [63:0] w_rd;

  // Arbitration: a lone requester wins; on contention the port that did not
  // win last time is picked.
  logic        w_pick;
  logic        w_sel_we;
  logic [63:0] w_sel_addr;
  logic [63:0] w_sel_wdata;
  logic        w_sel_ok;

  assign w_pick      = (p0_req && p1_req) ? ~r_last : p1_req;
  assign w_sel_we    = w_pick ? p1_we    : p0_we;
  assign w_sel_addr  = w_pick ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_pick ? p1_wdata : p0_wdata;
  assign w_sel_ok    = (w_sel_addr <= c_max_addr);

  // Read data is only meaningful for an in-bounds read.
  assign w_rd = (!r_oob && !r_we) ? mem_out : 64'd0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and next-output decode; every output defaults to idle values.
  always_comb begin
    w_state_nx    = r_state;
    w_grant       = 1'b0;
    w_busy_nx     = 1'b0;
    w_p0_ack_nx   = 1'b0;
    w_p1_ack_nx   = 1'b0;
    w_p0_err_nx   = 1'b0;
    w_p1_err_nx   = 1'b0;
    w_p0_rdata_nx = 64'd0;
    w_p1_rdata_nx = 64'd0;
    w_mem_rd_nx   = 1'b0;
    w_mem_wr_nx   = 1'b0;
    w_mem_add_nx  = 64'd0;
    w_mem_in_nx   = 64'd0;
    case (r_state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          w_grant      = 1'b1;
          w_state_nx   = S_ACCESS;
          w_busy_nx    = 1'b1;
          // Memory controls are set up at the grant edge so they are stable
          // for the whole ACCESS cycle, including the committing falling edge.
          w_mem_rd_nx  = w_sel_ok && !w_sel_we;
          w_mem_wr_nx  = w_sel_ok && w_sel_we;
          w_mem_add_nx = w_sel_ok ? w_sel_addr : 64'd0;
          w_mem_in_nx  = (w_sel_ok && w_sel_we) ? w_sel_wdata : 64'd0;
        end
      end
      S_ACCESS: begin
        w_state_nx    = S_RESP;
        w_busy_nx     = 1'b1;
        w_p0_ack_nx   = !r_grant_id;
        w_p1_ack_nx   = r_grant_id;
        w_p0_err_nx   = !r_grant_id && r_oob;
        w_p1_err_nx   = r_grant_id && r_oob;
        w_p0_rdata_nx = r_grant_id ? 64'd0 : w_rd;
        w_p1_rdata_nx = r_grant_id ? w_rd : 64'd0;
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Output registers and grant context; reset drops any pending transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_oob      <= 1'b0;
      r_last     <= ~PRIO_RESET;
      r_grant_id <= 1'b0;
      r_busy     <= 1'b0;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p0_rdata <= 64'd0;
      r_p1_rdata <= 64'd0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_add  <= 64'd0;
      r_mem_in   <= 64'd0;
    end else begin
      if (w_grant) begin
        r_we       <= w_sel_we;
        r_oob      <= !w_sel_ok;
        r_last     <= w_pick;
        r_grant_id <= w_pick;
      end
      r_busy     <= w_busy_nx;
      r_p0_ack   <= w_p0_ack_nx;
      r_p1_ack   <= w_p1_ack_nx;
      r_p0_err   <= w_p0_err_nx;
      r_p1_err   <= w_p1_err_nx;
      r_p0_rdata <= w_p0_rdata_nx;
      r_p1_rdata <= w_p1_rdata_nx;
      r_mem_rd   <= w_mem_rd_nx;
      r_mem_wr   <= w_mem_wr_nx;
      r_mem_add  <= w_mem_add_nx;
      r_mem_in   <= w_mem_in_nx;
    end
  end

  assign p0_ack   = r_p0_ack;
  assign p1_ack   = r_p1_ack;
  assign p0_err   = r_p0_err;
  assign p1_err   = r_p1_err;
  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;
  assign mem_rd   = r_mem_rd;
  assign mem_wr   = r_mem_wr;
  assign mem_add  = r_mem_add;
  assign mem_in   = r_mem_in;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a byte-array memory,
//               a transaction-level reference model and a separate monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int MB = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic        mem_rd, mem_wr;
  logic [63:0] mem_add, mem_in, mem_out;
  logic        busy, grant_id;

  dmem_arbiter #(.MEM_BYTES(MB), .PRIO_RESET(1'b0)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_add(mem_add), .mem_in(mem_in),
    .mem_out(mem_out), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT and the reference copy.
  logic [7:0] mem [MB];
  logic [7:0] ref_mem [MB];

  // Combinational big-endian doubleword read.
  always_comb begin
    mem_out = 64'd0;
    for (int i = 0; i < 8; i++) mem_out[63-8*i -: 8] = mem[mem_add[7:0] + 8'(i)];
  end

  // Memory initialisation, then writes committing on the falling edge.
  initial begin
    for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h5A;
    forever begin
      @(negedge clk);
      if (mem_wr)
        for (int i = 0; i < 8; i++) mem[mem_add[7:0] + 8'(i)] = mem_in[63-8*i -: 8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected responses per port and expected grant order.
  typedef struct {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   qg[$];
  bit   ref_last;

  function automatic logic [63:0] ref_rd(input int a);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 8; i++) v = {v[55:0], ref_mem[a+i]};
    return v;
  endfunction

  task automatic predict(input bit port, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata);
    exp_t e;
    e.err   = (addr > 64'(MB - 8));
    e.rdata = 64'd0;
    if (!e.err) begin
      if (we) for (int i = 0; i < 8; i++) ref_mem[int'(addr[7:0]) + i] = wdata[63-8*i -: 8];
      else    e.rdata = ref_rd(int'(addr[7:0]));
    end
    if (port) q1.push_back(e);
    else      q0.push_back(e);
    qg.push_back(port);
    ref_last = port;
  endtask

  // Monitor state.
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          n_ack0 = 0;
  bit          prev_ack0, prev_ack1;
  bit          ack_log[$];
  logic        last_err0, last_err1;
  logic [63:0] last_rd0, last_rd1;

  task automatic mon_ack(input bit port, input logic err, input logic [63:0] rdata,
                         input bit prev);
    exp_t e;
    chk($sformatf("p%0d_ack_len", port), 64'(prev), 64'd0);
    chk($sformatf("p%0d_busy", port), 64'(busy), 64'd1);
    chk($sformatf("p%0d_grant_id", port), 64'(grant_id), 64'(port));
    chk("grant_queue", 64'(qg.size() > 0), 64'd1);
    if (qg.size() > 0) chk("grant_order", 64'(qg.pop_front()), 64'(port));
    if (port) begin
      chk("p1_queue", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("p1_err", 64'(err), 64'(e.err));
        chk("p1_rdata", rdata, e.rdata);
      end
    end else begin
      chk("p0_queue", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("p0_err", 64'(err), 64'(e.err));
        chk("p0_rdata", rdata, e.rdata);
      end
    end
    ack_log.push_back(port);
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (reset) begin
      prev_ack0 = 1'b0;
      prev_ack1 = 1'b0;
    end else begin
      if (mem_rd) rd_cyc++;
      if (mem_wr) wr_cyc++;
      if (mem_rd || mem_wr) begin
        chk("mem_rd_wr_excl", 64'(mem_rd && mem_wr), 64'd0);
        chk("mem_add_bound", 64'(mem_add > 64'(MB - 8)), 64'd0);
      end else begin
        chk("mem_idle_zero", mem_add | mem_in, 64'd0);
      end
      if (p0_ack && p1_ack) chk("dual_ack", 64'(p0_ack && p1_ack), 64'd0);
      if (p0_ack) begin
        n_ack0++;
        last_err0 = p0_err;
        last_rd0  = p0_rdata;
        mon_ack(1'b0, p0_err, p0_rdata, prev_ack0);
      end
      if (p1_ack) begin
        last_err1 = p1_err;
        last_rd1  = p1_rdata;
        mon_ack(1'b1, p1_err, p1_rdata, prev_ack1);
      end
      prev_ack0 = p0_ack;
      prev_ack1 = p1_ack;
    end
  end

  // Issue n grants with the current operands held; both requesters alternate.
  task automatic run(input bit r0, input bit r1, input int n);
    int acks;
    int last_c;
    bit first;
    bit pt;
    acks   = 0;
    last_c = 0;
    first  = (r0 && r1) ? ~ref_last : r1;
    for (int k = 0; k < n; k++) begin
      pt = (r0 && r1) ? (first ^ k[0]) : first;
      if (pt) predict(1'b1, p1_we, p1_addr, p1_wdata);
      else    predict(1'b0, p0_we, p0_addr, p0_wdata);
    end
    @(negedge clk);
    p0_req = r0;
    p1_req = r1;
    for (int c = 0; c < 3 * n + 12 && acks < n; c++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        if (acks > 0) chk("ack_spacing", 64'(c - last_c), 64'd3);
        last_c = c;
        acks++;
      end
    end
    if (acks < n) chk("ack_timeout", 64'(acks), 64'(n));
    @(posedge clk);
    #1;
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctl"}, 64'({p0_ack, p1_ack, p0_err, p1_err, mem_rd, mem_wr, busy, grant_id}), 64'd0);
    chk({nm, "_data"}, p0_rdata | p1_rdata | mem_add | mem_in, 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return 64'(MB - 8);
      1:       return 64'(MB - 7 + int'($urandom_range(0, 6)));
      2:       return {$urandom | 32'h1, $urandom};
      default: return 64'($urandom_range(0, MB - 8));
    endcase
  endfunction

  task automatic rnd_ops();
    p0_we    = 1'($urandom);
    p1_we    = 1'($urandom);
    p0_addr  = rnd_addr();
    p1_addr  = rnd_addr();
    p0_wdata = rnd64();
    p1_wdata = rnd64();
  endtask

  int          base;
  logic [63:0] v;
  logic [3:0]  seq;

  initial begin
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = 64'd0; p1_addr = 64'd0; p0_wdata = 64'd0; p1_wdata = 64'd0;
    ref_last = 1'b1;
    #1;
    for (int i = 0; i < MB; i++) ref_mem[i] = mem[i];
    #1 reset = 1'b1;

    // Reset with random inputs: everything held at zero.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      p0_req = 1'($urandom); p1_req = 1'($urandom);
      rnd_ops();
      #1;
      check_all_zero("reset");
    end
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    reset = 1'b0;
    base = rd_cyc + wr_cyc;
    repeat (10) @(negedge clk);
    chk("idle_no_mem_access", 64'(rd_cyc + wr_cyc - base), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Continuous two-port contention right after reset.
    p0_we = 1'b1; p0_addr = 64'd64; p0_wdata = 64'h1111_2222_3333_4444;
    p1_we = 1'b0; p1_addr = 64'd64;
    ack_log.delete();
    run(1'b1, 1'b1, 4);
    seq = 4'hF;
    if (ack_log.size() >= 4) seq = {ack_log[0], ack_log[1], ack_log[2], ack_log[3]};
    chk("contention_seq", 64'(seq), 64'b0101);

    // Port 0 write then read back.
    p0_we = 1'b1; p0_addr = 64'd16; p0_wdata = 64'h0102_0304_0506_0708;
    base = wr_cyc;
    run(1'b1, 1'b0, 1);
    chk("write_pulse_len", 64'(wr_cyc - base), 64'd1);
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = mem[16 + i];
    chk("mem_bytes_16_23", v, 64'h0102_0304_0506_0708);
    p0_we = 1'b0;
    run(1'b1, 1'b0, 1);
    chk("p0_read16_data", last_rd0, 64'h0102_0304_0506_0708);
    chk("p0_read16_err", 64'(last_err0), 64'd0);

    // Bounds: 249 is an error without a memory read; 248 is legal.
    p1_we = 1'b0; p1_addr = 64'd249;
    base = rd_cyc;
    run(1'b0, 1'b1, 1);
    chk("oob_no_mem_rd", 64'(rd_cyc - base), 64'd0);
    chk("oob_err", 64'(last_err1), 64'd1);
    chk("oob_rdata", last_rd1, 64'd0);
    p1_addr = 64'd248;
    run(1'b0, 1'b1, 1);
    chk("edge248_err", 64'(last_err1), 64'd0);
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = mem[248 + i];
    chk("edge248_data", last_rd1, v);

    // Lone port 1 write, then port 0 reads it back.
    p1_we = 1'b1; p1_addr = 64'd40; p1_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    base = n_ack0;
    run(1'b0, 1'b1, 1);
    chk("p1_write_no_p0_ack", 64'(n_ack0 - base), 64'd0);
    chk("p1_write_rdata", last_rd1, 64'd0);
    p0_we = 1'b0; p0_addr = 64'd40;
    run(1'b1, 1'b0, 1);
    chk("p0_reads_p1_data", last_rd0, 64'hDEAD_BEEF_CAFE_F00D);

    // Reset inside ACCESS before the committing falling edge.
    @(negedge clk);
    p0_we = 1'b1; p0_addr = 64'd0; p0_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    p0_req = 1'b1;
    @(posedge clk);
    #1;
    chk("access_mem_wr", 64'(mem_wr), 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    ref_last = 1'b1;
    @(negedge clk);
    p0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    base = n_ack0;
    repeat (5) @(negedge clk);
    chk("mid_reset_no_ack", 64'(n_ack0 - base), 64'd0);
    chk("mid_reset_byte0", 64'(mem[0]), 64'(ref_mem[0]));
    p0_we = 1'b0; p1_we = 1'b0; p1_addr = 64'd8;
    ack_log.delete();
    run(1'b1, 1'b1, 2);
    chk("post_reset_first_grant", 64'(ack_log.size() > 0 ? ack_log[0] : 1'b1), 64'd0);

    // Randomized traffic.
    for (int r = 0; r < 150; r++) begin
      rnd_ops();
      case ($urandom_range(0, 3))
        0: repeat ($urandom_range(1, 3)) @(negedge clk);
        1: run(1'b1, 1'b0, int'($urandom_range(1, 2)));
        2: run(1'b0, 1'b1, int'($urandom_range(1, 2)));
        default: run(1'b1, 1'b1, ($urandom_range(0, 3) == 0) ? 4 : 2);
      endcase
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(q0.size() + q1.size() + qg.size()), 64'd0);
    for (int i = 0; i < MB; i++) v = (mem[i] !== ref_mem[i]) ? 64'(i + 1) : v;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 256-byte data memory of the pipelined core. Shares the memory's single read/write port between the pipeline MEM stage (port 0) and the debug/program-loader port (port 1) using round-robin arbitration. Replaces the memory's simulation-time `$stop` with a bounds check that completes the transaction with an error flag. Every transaction is a 64-bit big-endian doubleword access at a byte address.

## Interface
- `MEM_BYTES`, 256: memory size in bytes; the highest legal address is MEM_BYTES-8.
- `PRIO_RESET`, 0: port that wins the first two-way contention after reset.
- `clk`  in  1  clock; memory writes commit on its falling edge.
- `reset`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  request; held high until ack is sampled.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `p0_addr`, `p1_addr`  in  64  byte address; stable while req is high.
- `p0_wdata`, `p1_wdata`  in  64  write data; stable while req is high.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_err`, `p1_err`  out  1  valid with ack; the address was out of bounds.
- `p0_rdata`, `p1_rdata`  out  64  read data; valid with ack; 0 for writes and errors.
- `mem_rd`, `mem_wr`  out  1  memory control signals.
- `mem_add`  out  64  memory address.
- `mem_in`  out  64  memory write data.
- `mem_out`  in  64  combinational read data from memory.
- `busy`  out  1  high in ACCESS and RESP.
- `grant_id`  out  1  port owning the current transaction; holds its last value when idle.

## Operation
- FSM with three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE
  - Requests are sampled at each rising edge.
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both request: grant the port not equal to `last_grant`.
  - `last_grant` resets to the complement of PRIO_RESET, so the first contention goes to PRIO_RESET.
  - On a grant, latch we/addr/wdata/id, update `last_grant`, and go to ACCESS.
- ACCESS (exactly one cycle)
  - If addr ≤ MEM_BYTES-8: drive mem_add=addr and mem_rd=!we or mem_wr=we. Drive mem_in=wdata for writes.
  - If addr > MEM_BYTES-8: mem_rd=mem_wr=0 and set the error flag.
  - Go to RESP.
- RESP (one cycle)
  - The granted port's ack=1 and err=flag.
  - rdata = the mem_out value captured at the end of ACCESS for a good read, else 0.
  - Go to IDLE.
- Misaligned addresses within bounds are legal.
- In ACCESS and RESP, requests are ignored, not queued.
- All outputs are registered and reset to 0; `grant_id` resets to 0.
- When mem_rd/mem_wr are 0, mem_add and mem_in are driven to 0.

## Timing
- Edge t0: a request is sampled in IDLE.
- t0 to t1 (ACCESS): memory signals are stable. A write commits on the falling edge inside this cycle. Read data is captured at t1.
- t1 to t2 (RESP): ack/err/rdata are valid.
- Edge t2: state returns to IDLE. The requester sees ack at t2 and may drop req or change operands after t2.
- Next grant is sampled at t3 at the earliest. Peak throughput is one transaction every 3 cycles; completion latency is 2 cycles after the sampling edge.
- A requester that keeps req high after its ack is treated as a new request at t3.
- Reset mid-operation:
  - All outputs go to 0 immediately and asynchronously; mem_wr drops within the cycle.
  - A write whose falling edge has not yet occurred does not commit.
  - The pending transaction is dropped with no ack. `last_grant` is restored to its reset value.
- Bounds boundary (MEM_BYTES=256): addr 248 is legal; addr 249 and any address with a nonzero upper bit is an error.

## Test plan
- Reset: assert reset with random inputs → all outputs 0, busy=0. Deassert, no requests for 10 cycles → mem_rd=mem_wr=0 throughout.
- Write then read, port 0: write addr 16, data 0x0102030405060708 → mem_wr high for exactly one cycle, p0_ack at t1–t2, memory bytes 16..23 = 01..08. Read addr 16 → p0_rdata=0x0102030405060708, p0_err=0.
- Contention: both ports hold req continuously, PRIO_RESET=0 → grant_id sequence 0,1,0,1. Each ack pulse is one cycle on the correct port only, and a new grant starts every 3 cycles.
- Bounds: p1 reads addr 249 → mem_rd never asserted, p1_ack=1, p1_err=1, p1_rdata=0. Read at addr 248 → err=0 with data from bytes 248..255.
- Reset during write: p0 writes 0xFF.. to addr 0; reset asserts in ACCESS before the falling edge → mem_wr=0 immediately, no p0_ack, byte 0 unchanged.
- Single port 1 write with port 0 idle → grant_id=1, p1_rdata=0, p0_ack stays 0. A following port 0 read returns the port 1 data.
